mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the pipeline's instruction-fetch port and data-memory port onto one shared single-ported memory with variable-latency acknowledge. Sits between the fetch/memory stages and the unified memory model. Produces per-port stall signals for the hazard logic and discards fetches on wrong-path aborts (branch mispredict flush). Data accesses take priority, with an optional starvation guard for fetch.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 3, consecutive data grants tolerated while fetch waits (fairness build only; 1..7)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level; held with if_addr stable until if_ready or abort
- if_addr  in  AW  fetch address
- if_abort  in  1  discard current fetch (mispredict flush)
- if_ready  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched word, registered
- stall_if  out  1  if_req & ~if_ready
- d_req  in  1  data request, level; held stable until d_ready
- d_we  in  1  1 = write
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ready  out  1  one-cycle pulse: access complete
- d_rdata  out  DW  load data, registered
- stall_mem  out  1  d_req & ~d_ready
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_ack  in  1  one-cycle completion pulse; earliest in the first mem_req cycle
- mem_rdata  in  DW  valid with mem_ack

## Operation
- States: IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D, DRAIN.
- IDLE: d_req wins over if_req. Winner's addr/we/wdata are latched into mem_* and the FSM enters BUSY_x. If neither is requesting, stay.
- BUSY_x: mem_req=1, mem_* held. On mem_ack, capture mem_rdata into x_rdata and go to RESP_x. For writes the rdata register is unchanged.
- RESP_x: x_ready=1 for exactly this cycle, then IDLE. No grant is issued in RESP, so a requester still holding req in its ready cycle is not re-served.
- Abort: if_abort in BUSY_IF goes to DRAIN. DRAIN keeps mem_req until mem_ack, then goes to IDLE with no if_ready and no if_rdata update. if_abort in RESP_IF masks if_ready. if_abort in IDLE/BUSY_D/RESP_D has no effect. Data accesses are never aborted.
- stall_if and stall_mem are combinational from req and ready.

## Timing
- Reset values: state IDLE; mem_req, mem_we, if_ready, d_ready = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; starve_cnt = 0.
- Request seen in IDLE at cycle 0 → mem_req high at cycle 1 → ack at cycle 1+k (k≥0) → ready at cycle 2+k → IDLE at 3+k. The minimum request-to-ready latency is 2 cycles.
- Back-to-back service of the same port is possible every 3+k cycles.
- Reset asserted mid-transaction: mem_req drops asynchronously and the transaction is abandoned. The memory model must tolerate a dropped request.
- Simultaneous if_req and d_req in IDLE: data is granted, unless the fairness rule below applies.

## Configuration
- ARB_FAIR_EN defined: 3-bit starve_cnt.
  - Increments on each data grant while if_req=1.
  - Clears on a fetch grant or when if_req=0.
  - When starve_cnt==STARVE_MAX, the next IDLE tie goes to fetch.
- ARB_FAIR_EN undefined: strict data priority; starve_cnt is absent.

## Test plan
- Single fetch, addr 0x0000_0010, mem_ack 2 cycles after mem_req with rdata 0x2002_0005 → if_ready at cycle 4, if_rdata=0x2002_0005, stall_if high cycles 0–3.
- Store d_we=1 addr 0x44 wdata 0x7 with immediate ack → mem_we=1, mem_addr=0x44 at cycle 1, d_ready at cycle 2, d_rdata unchanged.
- if_req and d_req together in IDLE → data granted first. The fetch is granted in the IDLE cycle after RESP_D.
- if_abort in BUSY_IF, ack 3 cycles later → mem_req held until ack, no if_ready, if_rdata unchanged, new fetch granted afterward.
- ARB_FAIR_EN, STARVE_MAX=3, d_req and if_req held high → grant order D,D,D,IF,D…; without the macro, IF is never granted while d_req is high.
- rst low during BUSY_D → all outputs 0 immediately, state IDLE. After release, a pending d_req is granted fresh.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and shared-memory handshake bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory-model view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_abort;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          stall_if;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          stall_mem;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ready, if_rdata, stall_if, d_ready, d_rdata, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ready, if_rdata, stall_if, d_ready, d_rdata, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports, data first.
// Define ARB_FAIR_EN to add a starvation guard that hands a tie to fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef ARB_FAIR_EN
  ,parameter int STARVE_MAX = 3
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D, DRAIN} state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_rdy;
  logic          r_d_rdy;
  logic          w_fetch_pri;
  logic          w_gnt_d;
  logic          w_gnt_if;

  assign w_gnt_d  = bus.d_req & ~(w_fetch_pri & bus.if_req);
  assign w_gnt_if = bus.if_req & ~w_gnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_rdy    <= 1'b0;
      r_d_rdy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_d || w_gnt_if) begin
          r_state    <= w_gnt_d ? BUSY_D : BUSY_IF;
          r_mem_req  <= 1'b1;
          r_mem_we   <= w_gnt_d & bus.d_we;
          r_mem_addr <= w_gnt_d ? bus.d_addr : bus.if_addr;
          if (w_gnt_d) r_mem_wdata <= bus.d_wdata;
        end
        // An abort coinciding with the ack needs no drain: the access is already over.
        BUSY_IF: if (bus.mem_ack) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          if (bus.if_abort) r_state <= IDLE;
          else begin
            r_if_rdata <= bus.mem_rdata;
            r_if_rdy   <= 1'b1;
            r_state    <= RESP_IF;
          end
        end else if (bus.if_abort) r_state <= DRAIN;
        BUSY_D: if (bus.mem_ack) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          if (!r_mem_we) r_d_rdata <= bus.mem_rdata;
          r_d_rdy   <= 1'b1;
          r_state   <= RESP_D;
        end
        RESP_IF: begin
          r_if_rdy <= 1'b0;
          r_state  <= IDLE;
        end
        RESP_D: begin
          r_d_rdy <= 1'b0;
          r_state <= IDLE;
        end
        DRAIN: if (bus.mem_ack) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_FAIR_EN
  logic [2:0] r_starve;

  assign w_fetch_pri = r_starve == 3'(STARVE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_starve <= '0;
    else if (!bus.if_req || (r_state == IDLE && w_gnt_if)) r_starve <= '0;
    else if (r_state == IDLE && w_gnt_d && r_starve != 3'd7) r_starve <= r_starve + 3'd1;
  end
`else
  assign w_fetch_pri = 1'b0;
`endif

  // A flush in the response cycle suppresses the wrong-path word.
  assign bus.if_ready  = r_if_rdy & ~bus.if_abort;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.d_ready   = r_d_rdy;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.stall_mem = bus.d_req & ~bus.d_ready;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a variable-latency memory model.
// Build with ARB_FAIR_EN to check the fairness grant order instead of strict data priority.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_FAIR_EN
  localparam int SM = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {bit is_if; logic [DW-1:0] data;} exp_t;
  exp_t          sb[$];
  logic [AW-1:0] glog[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            lat = 0;
  int            wcnt = 0;
  int            n;
  logic [DW-1:0] rdval = '0;
  logic [DW-1:0] last_if;
  logic [AW-1:0] exp_a;
  logic          ack_m = 1'b0;
  logic [DW-1:0] rd_m = '0;
  logic          prev_req = 1'b0;

  assign bus.mem_ack   = ack_m;
  assign bus.mem_rdata = rd_m;

  // Memory model: acks lat cycles after the first mem_req cycle, returns rdval ^ address.
  always @(negedge clk) begin
    if (ack_m) begin
      ack_m = 1'b0;
      wcnt  = 0;
    end else if (bus.mem_req) begin
      if (wcnt >= lat) begin
        ack_m = 1'b1;
        rd_m  = rdval ^ bus.mem_addr;
      end else wcnt++;
    end else wcnt = 0;
    if (bus.mem_req && !prev_req) glog.push_back(bus.mem_addr);
    prev_req = bus.mem_req;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit is_if, input string tag, output int cyc);
    exp_t e;
    logic rdy;
    cyc = 0;
    @(negedge clk);
    rdy = is_if ? bus.if_ready : bus.d_ready;
    while (!rdy && cyc < 20) begin
      go();
      @(negedge clk);
      cyc++;
      rdy = is_if ? bus.if_ready : bus.d_ready;
    end
    chk_b({tag, "_ready"}, rdy, 1'b1);
    chk_b({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (rdy && sb.size() != 0) begin
      e = sb.pop_front();
      chk_b({tag, "_port"}, is_if, e.is_if);
      chk({tag, "_rdata"}, is_if ? bus.if_rdata : bus.d_rdata, e.data);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.if_abort = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_mem_req", bus.mem_req, 1'b0);
    chk_b("rst_mem_we", bus.mem_we, 1'b0);
    chk_b("rst_if_ready", bus.if_ready, 1'b0);
    chk_b("rst_d_ready", bus.d_ready, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_if_rdata", bus.if_rdata, '0);
    chk("rst_d_rdata", bus.d_rdata, '0);
    rst = 1;
    go();

    // Single fetch, ack two cycles after mem_req rises.
    lat = 2; rdval = 32'h2002_0015;
    bus.if_addr = 32'h10; bus.if_req = 1;
    sb.push_back('{1'b1, 32'h2002_0005});
    @(negedge clk);
    chk_b("t1_c0_stall_if", bus.stall_if, 1'b1);
    chk_b("t1_c0_mem_req", bus.mem_req, 1'b0);
    go();
    @(negedge clk);
    chk_b("t1_c1_mem_req", bus.mem_req, 1'b1);
    chk("t1_c1_mem_addr", bus.mem_addr, 32'h10);
    chk_b("t1_c1_mem_we", bus.mem_we, 1'b0);
    chk_b("t1_c1_stall_if", bus.stall_if, 1'b1);
    go();
    wait_ready(1'b1, "t1", n);
    chk("t1_latency", 32'(n), 32'd2);
    chk_b("t1_ready_stall_if", bus.stall_if, 1'b0);
    go();
    bus.if_req = 0;
    @(negedge clk);
    chk_b("t1_pulse_if_ready", bus.if_ready, 1'b0);
    chk_b("t1_after_mem_req", bus.mem_req, 1'b0);
    go();

    // Store with immediate ack; d_rdata must stay at its reset value.
    lat = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h44; bus.d_wdata = 32'h7;
    sb.push_back('{1'b0, 32'h0});
    @(negedge clk);
    chk_b("t2_c0_stall_mem", bus.stall_mem, 1'b1);
    go();
    @(negedge clk);
    chk_b("t2_c1_mem_req", bus.mem_req, 1'b1);
    chk_b("t2_c1_mem_we", bus.mem_we, 1'b1);
    chk("t2_c1_mem_addr", bus.mem_addr, 32'h44);
    chk("t2_c1_mem_wdata", bus.mem_wdata, 32'h7);
    go();
    wait_ready(1'b0, "t2", n);
    chk("t2_latency", 32'(n), 32'd0);
    chk_b("t2_ready_stall_mem", bus.stall_mem, 1'b0);
    go();
    bus.d_req = 0; bus.d_we = 0;
    @(negedge clk);
    chk_b("t2_pulse_d_ready", bus.d_ready, 1'b0);
    go();

    // Simultaneous requests: data load first, fetch in the IDLE after RESP_D.
    lat = 1; rdval = 32'h1234_5678;
    bus.d_req = 1; bus.d_addr = 32'h200; bus.if_req = 1; bus.if_addr = 32'h100;
    sb.push_back('{1'b0, 32'h1234_5678 ^ 32'h200});
    sb.push_back('{1'b1, 32'h1234_5678 ^ 32'h100});
    @(negedge clk);
    chk_b("t3_c0_stall_if", bus.stall_if, 1'b1);
    go();
    @(negedge clk);
    chk("t3_first_grant", bus.mem_addr, 32'h200);
    go();
    wait_ready(1'b0, "t3d", n);
    chk("t3d_latency", 32'(n), 32'd1);
    go();
    bus.d_req = 0;
    @(negedge clk);
    chk_b("t3_idle_mem_req", bus.mem_req, 1'b0);
    chk_b("t3_idle_stall_if", bus.stall_if, 1'b1);
    go();
    @(negedge clk);
    chk_b("t3_second_req", bus.mem_req, 1'b1);
    chk("t3_second_grant", bus.mem_addr, 32'h100);
    go();
    wait_ready(1'b1, "t3f", n);
    chk("t3f_latency", 32'(n), 32'd1);
    last_if = 32'h1234_5678 ^ 32'h100;
    go();
    bus.if_req = 0;

    // Abort in BUSY_IF: drain until the ack, no ready, then a new fetch.
    lat = 3;
    bus.if_req = 1; bus.if_addr = 32'h300;
    @(negedge clk);
    go();
    @(negedge clk);
    chk_b("t4_c1_mem_req", bus.mem_req, 1'b1);
    go();
    bus.if_abort = 1;
    @(negedge clk);
    go();
    bus.if_abort = 0; bus.if_req = 0;
    @(negedge clk);
    chk_b("t4_c3_drain_req", bus.mem_req, 1'b1);
    go();
    @(negedge clk);
    chk_b("t4_c4_drain_req", bus.mem_req, 1'b1);
    chk_b("t4_c4_if_ready", bus.if_ready, 1'b0);
    go();
    lat = 0;
    bus.if_req = 1; bus.if_addr = 32'h400;
    sb.push_back('{1'b1, 32'h1234_5678 ^ 32'h400});
    @(negedge clk);
    chk_b("t4_c5_mem_req", bus.mem_req, 1'b0);
    chk_b("t4_c5_if_ready", bus.if_ready, 1'b0);
    chk("t4_c5_if_rdata", bus.if_rdata, last_if);
    go();
    @(negedge clk);
    chk_b("t4_new_req", bus.mem_req, 1'b1);
    chk("t4_new_grant", bus.mem_addr, 32'h400);
    go();
    wait_ready(1'b1, "t4", n);
    chk("t4_latency", 32'(n), 32'd0);
    go();

    // Abort in RESP_IF masks the ready pulse.
    bus.if_addr = 32'h600;
    @(negedge clk);
    go();
    @(negedge clk);
    chk("t4b_grant", bus.mem_addr, 32'h600);
    go();
    bus.if_abort = 1;
    @(negedge clk);
    chk_b("t4b_masked_ready", bus.if_ready, 1'b0);
    chk_b("t4b_stall_if", bus.stall_if, 1'b1);
    go();
    bus.if_abort = 0; bus.if_req = 0;
    @(negedge clk);
    chk_b("t4b_after_ready", bus.if_ready, 1'b0);
    chk_b("t4b_after_mem_req", bus.mem_req, 1'b0);
    go();

    // Both ports held high: record the grant order.
    glog.delete();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.if_req = 1; bus.if_addr = 32'h100;
    repeat (26) go();
    bus.d_req = 0; bus.if_req = 0;
    repeat (5) go();
    chk_b("t5_grant_count", glog.size() >= 8, 1'b1);
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
`ifdef ARB_FAIR_EN
      exp_a = (i % (SM + 1) == SM) ? 32'h100 : 32'h200;
`else
      exp_a = 32'h200;
`endif
      chk($sformatf("t5_grant%0d", i), glog[i], exp_a);
    end
    @(negedge clk);
    chk_b("t5_idle_mem_req", bus.mem_req, 1'b0);
    go();

    // Reset during BUSY_D, then the held store is granted fresh.
    lat = 5;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h500; bus.d_wdata = 32'h99;
    @(negedge clk);
    go();
    @(negedge clk);
    chk_b("t6_busy_mem_req", bus.mem_req, 1'b1);
    go();
    lat = 0;
    rst = 0;
    #1;
    chk_b("t6_rst_mem_req", bus.mem_req, 1'b0);
    chk_b("t6_rst_mem_we", bus.mem_we, 1'b0);
    chk("t6_rst_mem_addr", bus.mem_addr, '0);
    chk("t6_rst_mem_wdata", bus.mem_wdata, '0);
    chk("t6_rst_if_rdata", bus.if_rdata, '0);
    chk("t6_rst_d_rdata", bus.d_rdata, '0);
    chk_b("t6_rst_d_ready", bus.d_ready, 1'b0);
    go();
    rst = 1;
    sb.push_back('{1'b0, 32'h0});
    @(negedge clk);
    chk_b("t6_idle_mem_req", bus.mem_req, 1'b0);
    go();
    @(negedge clk);
    chk_b("t6_regrant_req", bus.mem_req, 1'b1);
    chk_b("t6_regrant_we", bus.mem_we, 1'b1);
    chk("t6_regrant_addr", bus.mem_addr, 32'h500);
    chk("t6_regrant_wdata", bus.mem_wdata, 32'h99);
    go();
    wait_ready(1'b0, "t6", n);
    chk("t6_latency", 32'(n), 32'd0);
    go();
    bus.d_req = 0; bus.d_we = 0;
    repeat (2) go();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
